// File: rtl/usb_in_pkg.sv
// ============================================================================
// Module      : usb_in_pkg
// Description : Shared IN-endpoint types and sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_in_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HS = 2'd2
    } in_state_t;

    // Bits needed to index n items, never less than one
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // One slot stays empty so full and empty remain distinguishable
    function automatic int in_length(input int max_packet_size);
        return max_packet_size + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/in_fifo_rd_if.sv
// ============================================================================
// Module      : in_fifo_rd_if
// Description : IN FIFO read-side bus; in_level_o exists with IN_FIFO_RD_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface in_fifo_rd_if #(
    parameter int IN_MAX_PACKET_SIZE = 8
);
    localparam int IN_LENGTH = usb_in_pkg::in_length(IN_MAX_PACKET_SIZE);
    localparam int PW        = usb_in_pkg::ceil_log2(IN_LENGTH);

    logic [8*IN_LENGTH-1:0] in_fifo_i;
    logic [PW-1:0]          in_last_q_i;
    logic [PW-1:0]          in_last_qq_i;
    logic                   in_req_i;
    logic                   in_data_ack_i;
    logic                   in_ack_i;
    logic                   in_ready_i;
    logic [7:0]             in_data_o;
    logic                   in_valid_o;
    logic                   in_full_o;
`ifdef IN_FIFO_RD_LEVEL_EN
    logic [PW-1:0]          in_level_o;
`endif

    modport master (
        output in_fifo_i, in_last_q_i, in_last_qq_i,
        output in_req_i, in_data_ack_i, in_ack_i, in_ready_i,
        input  in_data_o, in_valid_o, in_full_o
`ifdef IN_FIFO_RD_LEVEL_EN
        , input in_level_o
`endif
    );

    modport slave (
        input  in_fifo_i, in_last_q_i, in_last_qq_i,
        input  in_req_i, in_data_ack_i, in_ack_i, in_ready_i,
        output in_data_o, in_valid_o, in_full_o
`ifdef IN_FIFO_RD_LEVEL_EN
        , output in_level_o
`endif
    );

endinterface

`default_nettype wire

// File: rtl/in_ptr_wrap.sv
// ============================================================================
// Module      : in_ptr_wrap
// Description : Modulo-LENGTH pointer incrementer (LENGTH-1 wraps to 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module in_ptr_wrap #(
    parameter int PW     = 4,
    parameter int LENGTH = 9
) (
    input  wire logic [PW-1:0] i_ptr,
    output logic      [PW-1:0] o_ptr
);

    localparam logic [PW-1:0] c_last = PW'(LENGTH - 1);

    assign o_ptr = (i_ptr == c_last) ? '0 : i_ptr + PW'(1);

endmodule

`default_nettype wire

// File: rtl/in_fifo_rd.sv
// ============================================================================
// Module      : in_fifo_rd
// Description : IN FIFO read controller with packet hold/retransmit until ACK.
//               Optional registered occupancy output: IN_FIFO_RD_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module in_fifo_rd
    import usb_in_pkg::*;
#(
    parameter int IN_MAX_PACKET_SIZE = 8
) (
    input  wire logic   clk_i,
    input  wire logic   reset_i,
    input  wire logic   clk_gate_i,
    in_fifo_rd_if.slave bus
);

    localparam int IN_LENGTH = in_length(IN_MAX_PACKET_SIZE);
    localparam int PW        = ceil_log2(IN_LENGTH);
    localparam int CW        = ceil_log2(IN_MAX_PACKET_SIZE + 1);

    localparam logic [CW-1:0] c_max_cnt = CW'(IN_MAX_PACKET_SIZE);

    in_state_t     r_state;
    logic [PW-1:0] r_first_q;
    logic [PW-1:0] r_first_qq;
    logic [CW-1:0] r_cnt_q;
    logic          r_full;

    logic [PW-1:0] w_first_qq_inc;
    logic [PW-1:0] w_last_q_inc;
    logic          w_valid;

    in_ptr_wrap #(.PW(PW), .LENGTH(IN_LENGTH)) u_first_qq_inc (
        .i_ptr (r_first_qq),
        .o_ptr (w_first_qq_inc)
    );

    in_ptr_wrap #(.PW(PW), .LENGTH(IN_LENGTH)) u_last_q_inc (
        .i_ptr (bus.in_last_q_i),
        .o_ptr (w_last_q_inc)
    );

    assign w_valid = (r_state == ST_SEND) &&
                     (r_first_qq != bus.in_last_qq_i) &&
                     (r_cnt_q < c_max_cnt);

    assign bus.in_valid_o = w_valid;
    assign bus.in_data_o  = bus.in_fifo_i[{r_first_qq, 3'b000} +: 8];
    assign bus.in_full_o  = r_full;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_first_q  <= '0;
            r_first_qq <= '0;
            r_cnt_q    <= '0;
            r_full     <= 1'b0;
        end else if (clk_gate_i) begin
            // Guards the committed read pointer, not the speculative one
            r_full <= (w_last_q_inc == r_first_q);
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_req_i) begin
                        r_cnt_q <= '0;
                        r_state <= ST_SEND;
                    end else begin
                        r_first_qq <= r_first_q;
                    end
                end
                ST_SEND: begin
                    if (bus.in_data_ack_i && w_valid) begin
                        r_first_qq <= w_first_qq_inc;
                        r_cnt_q    <= r_cnt_q + CW'(1);
                    end
                    if (bus.in_ready_i) r_state <= ST_WAIT_HS;
                end
                ST_WAIT_HS: begin
                    if (bus.in_ack_i) begin
                        // Commit; a simultaneous request starts from the new pointer
                        r_first_q <= r_first_qq;
                        if (bus.in_req_i) begin
                            r_cnt_q <= '0;
                            r_state <= ST_SEND;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.in_req_i) begin
                        r_first_qq <= r_first_q;
                        r_cnt_q    <= '0;
                        r_state    <= ST_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef IN_FIFO_RD_LEVEL_EN
    logic [PW-1:0] r_level;
    logic [PW-1:0] w_level;

    assign w_level = (bus.in_last_qq_i >= r_first_q) ?
                     (bus.in_last_qq_i - r_first_q) :
                     (bus.in_last_qq_i + PW'(IN_LENGTH) - r_first_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)         r_level <= '0;
        else if (clk_gate_i) r_level <= w_level;
    end

    assign bus.in_level_o = r_level;
`endif

endmodule

`default_nettype wire

// File: tb/tb_in_fifo_rd.sv
// ============================================================================
// Module      : tb_in_fifo_rd
// Description : Directed self-checking bench for in_fifo_rd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_in_fifo_rd;

    localparam int MPS = 8;
    localparam int LEN = MPS + 1;

    logic clk_i = 1'b0;
    logic reset_i;
    logic clk_gate_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [LEN];

    always #5 clk_i = ~clk_i;

    in_fifo_rd_if #(.IN_MAX_PACKET_SIZE(MPS)) bus ();

    in_fifo_rd #(.IN_MAX_PACKET_SIZE(MPS)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clk_gate_i (clk_gate_i),
        .bus        (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_byte(input int k, input logic [7:0] v);
        mem[k] = v;
        bus.in_fifo_i[8*k +: 8] = v;
    endtask

    task automatic set_ptrs(input logic [3:0] lq, input logic [3:0] lqq);
        bus.in_last_q_i  = lq;
        bus.in_last_qq_i = lqq;
    endtask

    task automatic do_req();
        bus.in_req_i = 1'b1; cyc(); bus.in_req_i = 1'b0;
    endtask

    task automatic do_ready();
        bus.in_ready_i = 1'b1; cyc(); bus.in_ready_i = 1'b0;
    endtask

    task automatic do_ack();
        bus.in_ack_i = 1'b1; cyc(); bus.in_ack_i = 1'b0;
    endtask

    task automatic send_packet(input string tag, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(bus.in_valid_o), 32'd1);
            check({tag, "_data"},  32'(bus.in_data_o),  32'(mem[(start + i) % LEN]));
            bus.in_data_ack_i = 1'b1; cyc(); bus.in_data_ack_i = 1'b0;
        end
    endtask

    initial begin
        reset_i    = 1'b1;
        clk_gate_i = 1'b1;
        bus.in_fifo_i     = '0;
        bus.in_req_i      = 1'b0;
        bus.in_data_ack_i = 1'b0;
        bus.in_ack_i      = 1'b0;
        bus.in_ready_i    = 1'b0;
        set_ptrs(4'd0, 4'd0);
        for (int k = 0; k < LEN; k++) mem[k] = 8'h00;

        // Reset values
        cyc(3);
        check("rst_valid", 32'(bus.in_valid_o), 32'd0);
        check("rst_data",  32'(bus.in_data_o),  32'd0);
        check("rst_full",  32'(bus.in_full_o),  32'd0);
`ifdef IN_FIFO_RD_LEVEL_EN
        check("rst_level", 32'(bus.in_level_o), 32'd0);
`endif
        reset_i = 1'b0;
        cyc(3);
        check("idle_valid", 32'(bus.in_valid_o), 32'd0);
        check("idle_full",  32'(bus.in_full_o),  32'd0);

        // Basic 3-byte packet
        set_byte(0, 8'hA1); set_byte(1, 8'hA2); set_byte(2, 8'hA3);
        set_byte(3, 8'hB1); set_byte(4, 8'hB2);
        set_ptrs(4'd3, 4'd3);
        do_req();
        send_packet("basic", 0, 3);
        check("basic_empty_valid", 32'(bus.in_valid_o), 32'd0);
        bus.in_data_ack_i = 1'b1; cyc(); bus.in_data_ack_i = 1'b0;
        check("ack_ignored_data", 32'(bus.in_data_o), 32'hB1);
        do_ready();
        check("wait_valid", 32'(bus.in_valid_o), 32'd0);

        // Host retry: rewind and resend identically
        do_req();
        send_packet("retry", 0, 3);
        check("retry_empty_valid", 32'(bus.in_valid_o), 32'd0);
        do_ready();
        do_ack();

        // Committed pointer is now 3
        set_ptrs(4'd5, 4'd5);
        do_req();
`ifdef IN_FIFO_RD_LEVEL_EN
        check("level_2", 32'(bus.in_level_o), 32'd2);
`endif
        send_packet("commit", 3, 2);
        do_ready();
        do_ack();

        // Advance committed pointer to 6 with a one-byte packet
        set_byte(5, 8'hC0);
        set_ptrs(4'd6, 4'd6);
        do_req();
        send_packet("one", 5, 1);
        do_ready();
        do_ack();

        // Max packet with pointer wrap: 8 bytes at 6,7,8,0..4
        for (int i = 0; i < 8; i++) set_byte((6 + i) % LEN, 8'(8'h60 + i));
        set_ptrs(4'd5, 4'd5);
        cyc();
        check("wrap_full", 32'(bus.in_full_o), 32'd1);
        do_req();
        send_packet("wrap", 6, 8);
        check("wrap_end_valid", 32'(bus.in_valid_o), 32'd0);
        do_ready();
        do_ack();

        // Two more bytes after commit (first_q = 5)
        set_byte(5, 8'hD0); set_byte(6, 8'hD1);
        set_ptrs(4'd7, 4'd7);
        cyc();
        check("rest_full", 32'(bus.in_full_o), 32'd0);
        do_req();
        send_packet("rest", 5, 2);
        check("rest_end_valid", 32'(bus.in_valid_o), 32'd0);
        do_ready();
        do_ack();

        // Reset mid-packet returns to idle immediately
        set_byte(7, 8'hE7);
        set_ptrs(4'd8, 4'd8);
        do_req();
        check("mid_valid", 32'(bus.in_valid_o), 32'd1);
        check("mid_data",  32'(bus.in_data_o),  32'hE7);
        reset_i = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.in_valid_o), 32'd0);
        check("mid_rst_data",  32'(bus.in_data_o),  32'(mem[0]));
        cyc();
        reset_i = 1'b0;

        // Full: first_q = 0, last_q = 8
        for (int k = 0; k < LEN; k++) set_byte(k, 8'(8'h10 + k));
        cyc();
        check("full_set", 32'(bus.in_full_o), 32'd1);
        do_req();
        send_packet("full_pkt", 0, 1);
        do_ready();
        do_ack();
        check("full_lag", 32'(bus.in_full_o), 32'd1);
        cyc();
        check("full_clear", 32'(bus.in_full_o), 32'd0);

        // Gating freezes pointers while ack is held
        do_req();
        check("gate_start", 32'(bus.in_data_o), 32'h11);
        clk_gate_i = 1'b0;
        bus.in_data_ack_i = 1'b1;
        cyc(3);
        check("gate_hold_data",  32'(bus.in_data_o),  32'h11);
        check("gate_hold_valid", 32'(bus.in_valid_o), 32'd1);
        clk_gate_i = 1'b1;
        cyc();
        bus.in_data_ack_i = 1'b0;
        check("gate_step", 32'(bus.in_data_o), 32'h12);

        // Ack and request together: commit then send from the new pointer
        do_ready();
        bus.in_ack_i = 1'b1;
        bus.in_req_i = 1'b1;
        cyc();
        bus.in_ack_i = 1'b0;
        bus.in_req_i = 1'b0;
        check("ackreq_valid", 32'(bus.in_valid_o), 32'd1);
        check("ackreq_data",  32'(bus.in_data_o),  32'h12);
`ifdef IN_FIFO_RD_LEVEL_EN
        cyc();
        check("level_6", 32'(bus.in_level_o), 32'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
